// File: rtl/dfe_tone_pkg.sv
// Shared constants, FSM state type and quarter-wave table generator for interferer_tone_gen.
package dfe_tone_pkg;

    localparam int NUM_TONES = 3;

    // Increments for a 24-bit accumulator at an 18 MHz sample rate
    localparam logic [23:0] INC_1M  = 24'd932068;
    localparam logic [23:0] INC_2M4 = 24'd2236962;
    localparam logic [23:0] INC_2M  = 24'd1864135;
    localparam logic [NUM_TONES-1:0][23:0] TONE_INC = {INC_2M, INC_2M4, INC_1M};

    localparam int TONE_AMP = 8191;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    localparam longint PI_Q30 = 64'sd3373259426;

    // round(TONE_AMP * sin((2*idx+1)*pi/(4*2^aw))) via a Q30 Taylor series, elaboration only
    function automatic int lut_entry(input int idx, input int aw);
        longint x, x2, term, acc;
        x    = longint'(2 * idx + 1) * PI_Q30 / (longint'(4) << aw);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return int'((acc * longint'(TONE_AMP) + (longint'(1) << 29)) >>> 30);
    endfunction

endpackage

// File: rtl/quarter_wave_sin_lut.sv
// Registered quarter-wave sine ROM; the table is built at elaboration from dfe_tone_pkg::lut_entry.
module quarter_wave_sin_lut
    import dfe_tone_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LUT_AW     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LUT_AW-1:0]            addr,
    output logic signed [DATA_WIDTH-1:0] data
);

    logic signed [DATA_WIDTH-1:0] rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam logic signed [DATA_WIDTH-1:0] VAL = DATA_WIDTH'(lut_entry(g, LUT_AW));
        assign rom[g] = VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) data <= '0;
        else     data <= rom[addr];
    end

endmodule

// File: rtl/interferer_tone_gen.sv
// Three-tone CW interferer injector: x_in plus masked tones, 3-stage pipeline, saturated output.
// Optional INJ_DITHER_EN adds a per-sample LFSR LSB to the pre-saturation sum.
module interferer_tone_gen
    import dfe_tone_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int LUT_AW      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic [2:0]                   tone_mask,
    input  logic [15:0]                  burst_len,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic                         tone_on,
    output logic                         busy,
    output logic                         done
);

    localparam int STAGES = 3;
    localparam int SW     = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic   flush_cnt;
    logic   accept, issue, last;

    logic [NUM_TONES-1:0]                  mask_q;
    logic [15:0]                           len_q, cnt;
    logic [NUM_TONES-1:0][PHASE_WIDTH-1:0] acc;

    logic [STAGES:1]                       vld_pipe, last_pipe;
    logic [NUM_TONES-1:0][LUT_AW-1:0]      idx_s1;
    logic [NUM_TONES-1:0]                  neg_s1, en_s1, neg_s2, en_s2;
    logic signed [DATA_WIDTH-1:0]          x_d1, x_d2;
    logic signed [DATA_WIDTH-1:0]          lut_q    [NUM_TONES];
    logic signed [DATA_WIDTH-1:0]          tone_val [NUM_TONES];
    logic signed [SW-1:0]                  sum;
    logic signed [DATA_WIDTH-1:0]          y_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
        end
    end

    // done blocks start for one cycle so busy stays high through the done cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        last      = 1'b0;
        unique case (state)
            ST_IDLE: if (start && !done) begin
                accept    = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                issue = 1'b1;
                if (stop || (len_q != 16'd0 && cnt == len_q - 16'd1)) begin
                    last      = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: if (flush_cnt) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            acc    <= '0;
        end else if (accept) begin
            mask_q <= tone_mask;
            len_q  <= burst_len;
            cnt    <= '0;
            acc    <= '0;
        end else if (issue) begin
            cnt <= cnt + 16'd1;
            for (int t = 0; t < NUM_TONES; t++)
                if (mask_q[t]) acc[t] <= acc[t] + PHASE_WIDTH'(TONE_INC[t]);
        end
    end

    // S1: quadrant fold; S2: ROM read (inside the LUT instances); S3: sum and saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            idx_s1    <= '0;
            neg_s1    <= '0;
            en_s1     <= '0;
            neg_s2    <= '0;
            en_s2     <= '0;
            x_d1      <= '0;
            x_d2      <= '0;
            y_out     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], issue};
            last_pipe <= {last_pipe[STAGES-1:1], last};
            for (int t = 0; t < NUM_TONES; t++) begin
                idx_s1[t] <= acc[t][PHASE_WIDTH-2] ? ~acc[t][PHASE_WIDTH-3 -: LUT_AW]
                                                   :  acc[t][PHASE_WIDTH-3 -: LUT_AW];
                neg_s1[t] <= acc[t][PHASE_WIDTH-1];
                en_s1[t]  <= issue & mask_q[t];
            end
            neg_s2 <= neg_s1;
            en_s2  <= en_s1;
            x_d1   <= x_in;
            x_d2   <= x_d1;
            y_out  <= y_sat;
        end
    end

    for (genvar t = 0; t < NUM_TONES; t++) begin : g_tone
        quarter_wave_sin_lut #(
            .DATA_WIDTH (DATA_WIDTH),
            .LUT_AW     (LUT_AW)
        ) u_lut (
            .clk  (clk),
            .rst  (rst),
            .addr (idx_s1[t]),
            .data (lut_q[t])
        );
        assign tone_val[t] = en_s2[t] ? (neg_s2[t] ? -lut_q[t] : lut_q[t]) : '0;
    end

`ifdef INJ_DITHER_EN
    logic [15:0] lfsr;
    logic        dith_s1, dith_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            dith_s1 <= 1'b0;
            dith_s2 <= 1'b0;
        end else begin
            if (accept)     lfsr <= LFSR_SEED;
            else if (issue) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            dith_s1 <= issue & lfsr[0];
            dith_s2 <= dith_s1;
        end
    end
`endif

    always_comb begin
        sum = SW'(x_d2);
        for (int t = 0; t < NUM_TONES; t++) sum = sum + SW'(tone_val[t]);
`ifdef INJ_DITHER_EN
        sum = sum + SW'(dith_s2);
`endif
        if (sum > SAT_MAX)      y_sat = DATA_WIDTH'(SAT_MAX);
        else if (sum < SAT_MIN) y_sat = DATA_WIDTH'(SAT_MIN);
        else                    y_sat = sum[DATA_WIDTH-1:0];
    end

    assign tone_on = vld_pipe[STAGES];
    assign done    = last_pipe[STAGES];
    assign busy    = (state != ST_IDLE) || done;

endmodule
